// File: rtl/instr_loader.sv
// instr_loader: fills an instruction memory from a byte stream.
// The stream begins with a one-byte word count N (1..DEPTH), followed by
// 4*N data bytes, little-endian per 32-bit word. Each assembled word is
// written with a single-cycle mem_we at address word_cnt. The processor is
// held while a load is in progress.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 single-cycle request to begin a load
//   in_valid/in_data      byte stream in; in_ready out (transfer = valid & ready)
//   mem_we/addr/wdata     instruction-memory write port
//   cpu_hold, busy        high while a load is in progress
//   done, error           sticky result of the last load, cleared on start
module instr_loader #(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR     = 3'd1,
      COLLECT = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4,
      ERR     = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic [7:0]          n_q, n_d;
   logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
   logic [1:0]          byte_cnt_q, byte_cnt_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                in_ready_q, in_ready_d;
   logic                mem_we_q, mem_we_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                xfer_c;
   logic                last_word_c;

   assign xfer_c      = in_valid & in_ready_q;
   assign last_word_c = (32'(word_cnt_q) + 32'd1) == 32'(n_q);

   // Next-state and registered-output logic. Status outputs are derived
   // from the next state so they line up with the state register.
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      word_cnt_d = word_cnt_q;
      byte_cnt_d = byte_cnt_q;
      wdata_d    = wdata_q;
      done_d     = done_q;
      error_d    = error_q;

      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = HDR;
               done_d  = 1'b0;
               error_d = 1'b0;
            end
         end
         HDR: begin
            if (xfer_c) begin
               n_d = in_data;
               if (in_data == 8'd0 || 32'(in_data) > DEPTH) begin
                  state_d = ERR;
                  error_d = 1'b1;
               end else begin
                  state_d    = COLLECT;
                  word_cnt_d = '0;
                  byte_cnt_d = 2'd0;
               end
            end
         end
         COLLECT: begin
            if (xfer_c) begin
               case (byte_cnt_q)
                  2'd0:    wdata_d[7:0]   = in_data;
                  2'd1:    wdata_d[15:8]  = in_data;
                  2'd2:    wdata_d[23:16] = in_data;
                  default: wdata_d[31:24] = in_data;
               endcase
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            // Count stops at N-1, so it never wraps for a DEPTH-word load.
            if (last_word_c) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               state_d    = COLLECT;
               word_cnt_d = word_cnt_q + ADDR_W'(1);
               byte_cnt_d = 2'd0;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d = (state_d == HDR) || (state_d == COLLECT);
      mem_we_d   = (state_d == WRITE);
      busy_d     = in_ready_d || mem_we_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         n_q        <= 8'd0;
         word_cnt_q <= '0;
         byte_cnt_q <= 2'd0;
         wdata_q    <= 32'd0;
         in_ready_q <= 1'b0;
         mem_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         word_cnt_q <= word_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         wdata_q    <= wdata_d;
         in_ready_q <= in_ready_d;
         mem_we_q   <= mem_we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = word_cnt_q;
   assign mem_wdata = wdata_q;
   assign busy      = busy_q;
   assign cpu_hold  = busy_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter: DEPTH, default 32, number of 32-bit instruction words in the target instruction memory.
REQ-002 Parameter: ADDR_W, default 5, word-address width, with DEPTH <= 2**ADDR_W.
REQ-003 Port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: start, input, 1, single-cycle request to begin a load.
REQ-006 Port: in_valid, input, 1, byte-stream valid.
REQ-007 Port: in_data, input, 8, byte-stream data.
REQ-008 Port: in_ready, output, 1, loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-009 Port: mem_we, output, 1, instruction-memory write strobe.
REQ-010 Port: mem_addr, output, ADDR_W, word index to write.
REQ-011 Port: mem_wdata, output, 32, instruction word to write.
REQ-012 Port: cpu_hold, output, 1, holds the processor (PC) while a load is in progress.
REQ-013 Port: busy, output, 1, a load is in progress.
REQ-014 Port: done, output, 1, last load completed; sticky until the next accepted start.
REQ-015 Port: error, output, 1, last load aborted on a bad header; sticky until the next accepted start.

Function
REQ-016 FSM states: IDLE, HDR, COLLECT, WRITE, DONE, ERR.
REQ-017 IDLE, DONE, ERR: in_ready=0, busy=0, cpu_hold=0; start=1 -> HDR with done and error cleared.
REQ-018 HDR, COLLECT, WRITE: busy=1 and cpu_hold=1; start is ignored.
REQ-019 HDR: in_ready=1; the first accepted byte is the word count N.
REQ-020 HDR exits: N==0 or N>DEPTH -> ERR; otherwise -> COLLECT with word_cnt=0 and byte_cnt=0.
REQ-021 COLLECT: in_ready=1; accepted byte k (0..3) loads mem_wdata[8k+7:8k] (little-endian); the 4th accepted byte -> WRITE.
REQ-022 WRITE: exactly one cycle with mem_we=1, mem_addr=word_cnt, mem_wdata=assembled word, in_ready=0.
REQ-023 After WRITE: word_cnt+1==N -> DONE (done=1); else word_cnt increments -> COLLECT with byte_cnt=0.
REQ-024 mem_addr equals word_cnt at all times outside reset; mem_wdata holds the last assembled word while mem_we=0.
REQ-025 Minimum throughput: 5 cycles per word (4 byte transfers + 1 write cycle).
REQ-026 in_valid while in_ready=0: byte not consumed; no state change.
REQ-027 Gaps in in_valid stall the FSM without losing partially assembled bytes.
REQ-028 Addresses >= N are never written; word_cnt never wraps (a DEPTH-word load ends with a write to DEPTH-1).
REQ-029 ERR: error=1; no mem_we is ever issued during a load that ends in ERR.

Reset
REQ-030 rst_n low immediately, without waiting for clk: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, error=0.
REQ-031 Reset mid-load discards the partial word with no further write; words already written stay in memory; a new start after reset loads normally.

Verification
REQ-032 Normal load: start; bytes 02, 83 20 00 00, 83 20 10 00 -> write addr0=0x00002083, then addr1=0x00102083; done=1 and cpu_hold=0 the cycle after the second write.
REQ-033 Zero header: start; byte 00 -> error=1, cpu_hold=0, mem_we never asserted.
REQ-034 Oversize header: start; byte 21 (33 > DEPTH) -> error=1, no write; a following start with byte 01 plus 4 bytes clears error and writes addr0.
REQ-035 Stalled stream: same stimulus as REQ-032 with in_valid randomly low and start pulsed mid-load -> identical writes, start ignored, each mem_we exactly one cycle.
REQ-036 Reset mid-word: rst_n low after 2 data bytes -> all outputs at reset values asynchronously and no write; then a full REQ-032 load succeeds.
REQ-037 Full depth: header 20 (32) plus 128 bytes -> 32 writes to addresses 0..31 in order, last write to addr 31, no write to addr 0 after it, done=1.
